// File: rtl/ntsc_pkg.sv
// rtl/ntsc_pkg.sv - shared sample type and strobe helper for the NTSC datapath
package ntsc_pkg;

  typedef logic signed [31:0] sample_t;

  // Widest byte-strobe the helper can build (512-bit stream).
  localparam int unsigned MAX_STRB_W = 64;

  // All-ones strobe of n lanes, zero above; callers slice the low n bits.
  function automatic logic [MAX_STRB_W-1:0] strb_all_ones(input int unsigned n);
    logic [MAX_STRB_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_STRB_W; i++) begin
      if (i < n) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_delay_line.sv
// rtl/sample_delay_line.sv - N-deep circular sample buffer, read-old/write-new port
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : store wr_data at the write pointer and advance it
//   clear      : zero every entry and the pointer (wins over wr_en)
//   wr_data    : incoming sample
//   rd_data    : entry at the write pointer, i.e. the sample being evicted
module sample_delay_line #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;

  // The oldest sample sits where the next write lands.
  assign rd_data = mem[wr_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
      wr_ptr      <= wr_ptr + 1'b1;  // power-of-two depth wraps naturally
    end
  end

endmodule

// File: rtl/boxcar_decimator.sv
// rtl/boxcar_decimator.sv - power-of-two moving average followed by decimation
// Ports:
//   s00_axis_aclk, s00_axis_aresetn : clock, asynchronous active-low reset
//   s00_axis_t*                     : signed mixer samples in (tstrb ignored)
//   m00_axis_t*                     : filtered, decimated samples out; tlast
//                                     marks the end of a line
module boxcar_decimator
  import ntsc_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int LOG2_TAPS              = 4,
  parameter int DECIMATE               = 4,
  parameter int CLEAR_ON_LAST          = 1
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_aresetn,
  input  logic                                s00_axis_tvalid,
  output logic                                s00_axis_tready,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                m00_axis_tvalid,
  input  logic                                m00_axis_tready,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb
);

  localparam int IW     = C_S00_AXIS_TDATA_WIDTH;
  localparam int OW     = C_M00_AXIS_TDATA_WIDTH;
  localparam int AW     = IW + LOG2_TAPS;
  localparam int PW     = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam int STRB_W = OW / 8;

  localparam logic [PW-1:0]         PHASE_LAST = PW'(DECIMATE - 1);
  localparam logic [MAX_STRB_W-1:0] STRB_FULL  = strb_all_ones(STRB_W);

  logic                 accept;
  logic                 emit;
  logic                 clear;
  logic [IW-1:0]        hist_old;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] acc_next;
  logic signed [IW-1:0] mean;
  logic [PW-1:0]        phase;
  logic                 unused_tstrb;

  assign unused_tstrb = ^s00_axis_tstrb;

  // A new sample is taken whenever the output register is empty or draining.
  assign s00_axis_tready = !m00_axis_tvalid || m00_axis_tready;
  assign accept          = s00_axis_tvalid && s00_axis_tready;
  assign emit            = accept && (s00_axis_tlast || (phase == PHASE_LAST));
  assign clear           = accept && s00_axis_tlast && (CLEAR_ON_LAST != 0);

  // Running window sum: add the newcomer, drop the evicted sample.
  assign acc_next = acc + AW'($signed(s00_axis_tdata)) - AW'($signed(hist_old));

  // Divide by N with floor rounding; the mean of N IW-bit values fits in IW bits.
  assign mean = IW'(acc_next >>> LOG2_TAPS);

  assign m00_axis_tstrb = STRB_FULL[STRB_W-1:0];

  sample_delay_line #(
    .WIDTH      (IW),
    .DEPTH_LOG2 (LOG2_TAPS)
  ) u_delay_line (
    .clk     (s00_axis_aclk),
    .rst_n   (s00_axis_aresetn),
    .wr_en   (accept),
    .clear   (clear),
    .wr_data (s00_axis_tdata),
    .rd_data (hist_old)
  );

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      acc   <= '0;
      phase <= '0;
    end else if (accept) begin
      acc   <= clear ? '0 : acc_next;
      phase <= emit ? '0 : phase + 1'b1;  // tlast realigns decimation to the line
    end
  end

  // Output register: a load has priority; a drain without a load empties it.
  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tlast  <= 1'b0;
    end else if (emit) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= OW'(mean);  // signed cast sign-extends
      m00_axis_tlast  <= s00_axis_tlast;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

endmodule
